// File: rtl/clk_en_div.sv
// Clock-enable generator: runtime divisor, periodic/one-shot modes and a
// secondary sub-tick emitted on every SUB_DIV-th primary tick.
module clk_en_div #(
  parameter int CNT_W       = 27,
  parameter int DIV_DEFAULT = 100000000,
  parameter int SUB_DIV     = 4,
  parameter int SUB_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_en,
  output logic             sub_en,
  output logic             busy
);

  // state | meaning
  // IDLE  | counter held at 0, waiting for en (periodic) or en+start (one-shot)
  // RUN   | counting towards div_reg-1, ticking on the terminal count
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_DEFAULT);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] div_reg, count, count_nxt;
  logic [SUB_W-1:0] sub_cnt;
  logic             mode_reg, tick, terminal;

  assign terminal = (count == div_reg - CNT_W'(1));
  assign busy     = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A load always restarts the count and suppresses a coinciding tick;
  // dropping en aborts a run without ticking.
  always_comb begin
    state_nxt = state;
    count_nxt = '0;
    tick      = 1'b0;
    case (state)
      IDLE: begin
        if (!div_load && en && (!mode || start)) state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (div_load) begin
          count_nxt = '0;
        end else if (terminal) begin
          tick = 1'b1;
          if (mode_reg) state_nxt = IDLE;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      div_reg  <= DIV_RST;
      mode_reg <= 1'b0;
      sub_cnt  <= '0;
      clk_en   <= 1'b0;
      sub_en   <= 1'b0;
    end else begin
      count  <= count_nxt;
      clk_en <= tick;
      sub_en <= tick && (sub_cnt == SUB_LAST);
      if (state == IDLE) mode_reg <= mode;
      if (div_load) begin
        div_reg <= (div_in == '0) ? CNT_W'(1) : div_in;
        sub_cnt <= '0;
      end else if (tick) begin
        sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + SUB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_en_div.sv
// Scoreboard bench for clk_en_div: stimulus pushes expected ticks (cycle,
// sub_en, busy); a negedge monitor pops one entry per observed clk_en.
module tb_clk_en_div;

  localparam int CNT_W = 8;
  localparam int DIV_DEFAULT = 7;
  localparam int SUB_DIV = 4;
  localparam int SUB_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0, mode = 1'b0, start = 1'b0, div_load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic             clk_en, sub_en, busy;

  typedef struct {
    int   cyc;
    logic sub;
    logic bsy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   e, e2, l;

  clk_en_div #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT), .SUB_DIV(SUB_DIV), .SUB_W(SUB_W)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start),
    .div_load(div_load), .div_in(div_in),
    .clk_en(clk_en), .sub_en(sub_en), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic s, input logic b);
    exp_t x;
    x.cyc = c; x.sub = s; x.bsy = b;
    q.push_back(x);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic load(input int v);
    div_load = 1'b1;
    div_in   = CNT_W'(v);
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_pending"}, q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (clk_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick at cycle %0d: got clk_en=1 expected none", cyc);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("tick_cycle", cyc, x.cyc);
        chk("tick_sub_en", int'(sub_en), int'(x.sub));
        chk("tick_busy", int'(busy), int'(x.bsy));
      end
    end else if (sub_en) begin
      checks++;
      errors++;
      $display("FAIL sub_without_tick at cycle %0d: got sub_en=1 expected 0", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_sub_en", int'(sub_en), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    @(negedge clk);

    // periodic /3, sub-tick on the fourth primary tick
    load(3);
    mode = 1'b0; en = 1'b1; e = cyc + 1;
    push(e + 3, 0, 1); push(e + 6, 0, 1); push(e + 9, 0, 1); push(e + 12, 1, 1);
    wait_until(e + 5);
    chk("t1_busy", int'(busy), 1);
    wait_until(e + 12);
    en = 1'b0;
    wait_until(e + 14);
    chk("t1_busy_off", int'(busy), 0);
    chk_empty("t1");

    // divisor 0 behaves as 1: tick every cycle
    load(0);
    en = 1'b1; e = cyc + 1;
    for (int k = 1; k <= 8; k++) push(e + k, (k % 4) == 0, 1);
    wait_until(e + 8);
    en = 1'b0;
    wait_until(e + 10);
    chk_empty("t2");

    // one-shot /5 with an ignored retrigger
    load(5);
    mode = 1'b1; en = 1'b1; start = 1'b1; e = cyc + 1;
    push(e + 5, 0, 0);
    @(negedge clk);
    start = 1'b0;
    wait_until(e + 2);
    chk("t3_busy_run", int'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(e + 4);
    chk("t3_busy_late", int'(busy), 1);
    wait_until(e + 5);
    chk("t3_busy_done", int'(busy), 0);
    wait_until(e + 12);
    chk("t3_stays_idle", int'(busy), 0);
    chk_empty("t3");
    en = 1'b0; mode = 1'b0;

    // periodic /4, abort at terminal count, sub_cnt survives the gap
    load(4);
    en = 1'b1; e = cyc + 1;
    push(e + 4, 0, 1); push(e + 8, 0, 1);
    wait_until(e + 11);
    en = 1'b0;
    wait_until(e + 12);
    chk("t4_abort_idle", int'(busy), 0);
    wait_until(e + 13);
    en = 1'b1; e2 = cyc + 1;
    push(e2 + 4, 0, 1); push(e2 + 8, 1, 1);
    wait_until(e2 + 8);
    en = 1'b0;
    wait_until(e2 + 10);
    chk_empty("t4");

    // reload /10 -> /2 at count 7
    load(10);
    en = 1'b1; e = cyc + 1;
    push(e + 10, 0, 1);
    wait_until(e + 17);
    div_load = 1'b1; div_in = 8'd2; l = e + 18;
    @(negedge clk);
    div_load = 1'b0;
    chk("t5_busy_after_load", int'(busy), 1);
    push(l + 2, 0, 1); push(l + 4, 0, 1); push(l + 6, 0, 1); push(l + 8, 1, 1);
    wait_until(l + 8);
    en = 1'b0;
    wait_until(l + 10);
    chk_empty("t5");

    // asynchronous reset mid-run, then default divisor restored
    load(1);
    en = 1'b1; e = cyc + 1;
    push(e + 1, 0, 1); push(e + 2, 0, 1); push(e + 3, 0, 1);
    wait_until(e + 3);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_clk_en", int'(clk_en), 0);
    chk("t6_async_sub_en", int'(sub_en), 0);
    chk("t6_async_busy", int'(busy), 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("t6_idle_after_rst", int'(busy), 0);
    chk_empty("t6a");
    @(negedge clk);
    en = 1'b1; e = cyc + 1;
    push(e + 7, 0, 1);
    wait_until(e + 7);
    en = 1'b0;
    wait_until(e + 9);
    chk_empty("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_en_div.md
Name: clk_en_div

Overview:
- Parametrised clock-enable generator; successor to the fixed /100,000,000 tick used by the vending FSM.
- Adds a runtime-loadable divisor, periodic/one-shot modes, gating, a busy flag and a secondary sub-tick (every SUB_DIV primary ticks) for slower consumers such as display refresh or timeouts.
- Sits between the board clock and all FSMs needing slow strobes; every consumer stays on clk and qualifies its logic with clk_en/sub_en.

Parameters:
- CNT_W, 27, width of divisor and counter.
- DIV_DEFAULT, 100000000, divisor loaded at reset (must fit in CNT_W, >=1).
- SUB_DIV, 4, primary ticks per sub_en pulse (>=1).
- SUB_W, 8, width of sub-tick counter (2^SUB_W >= SUB_DIV).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  global enable; periodic mode runs while high; low aborts any run.
- mode  input  1  0 = periodic, 1 = one-shot; sampled only in IDLE.
- start  input  1  one-shot trigger; used only in IDLE with en=1, mode=1.
- div_load  input  1  load div_in into divisor register.
- div_in  input  CNT_W  new divisor; 0 is loaded as 1.
- clk_en  output  1  one-cycle primary tick (registered).
- sub_en  output  1  one-cycle secondary tick, coincident with every SUB_DIV-th clk_en (registered).
- busy  output  1  high while in RUN.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, count=0, sub_cnt=0, div_reg=DIV_DEFAULT.
  - clk_en=0, sub_en=0, busy=0.
- Registers: div_reg, count (0..div_reg-1), sub_cnt (0..SUB_DIV-1), mode_reg, 2-state FSM IDLE/RUN.
- IDLE:
  - count held 0; clk_en=sub_en=0; busy=0.
  - mode latched into mode_reg every IDLE cycle.
  - Periodic: en=1 -> RUN.
  - One-shot: en=1 and start=1 -> RUN.
- RUN:
  - busy=1; count increments each edge.
  - At count==div_reg-1: count->0 and clk_en=1 on the following cycle.
  - Period is exactly div_reg cycles. First clk_en occurs on the div_reg-th edge after the edge that moved IDLE->RUN.
  - div_reg=1 in periodic mode gives clk_en high every cycle.
- One-shot terminal:
  - On the terminal count, emit exactly one clk_en and return to IDLE on the same edge.
  - busy falls with clk_en high.
  - start pulses during RUN are ignored (no retrigger).
- en=0 in RUN: go to IDLE next edge; count cleared; no clk_en emitted that edge, even if it was the terminal count.
- mode changes during RUN are ignored until the next IDLE.
- sub_en:
  - sub_cnt advances on each emitted clk_en.
  - When sub_cnt==SUB_DIV-1 at a tick, sub_en=1 in the same cycle as clk_en, and sub_cnt wraps to 0.
  - SUB_DIV=1 makes sub_en identical to clk_en.
  - sub_cnt persists across en gating and one-shots; cleared only by reset or div_load.
- div_load:
  - div_reg <= (div_in==0 ? 1 : div_in); count and sub_cnt <= 0 on the same edge; state unchanged.
  - In RUN, the next clk_en arrives new-div_reg edges after the load edge.
  - A pending terminal tick on the load edge is suppressed; load wins.
  - div_load and start in the same cycle: load taken, start ignored, FSM stays IDLE.
- Width rule: count compares against div_reg-1 in CNT_W bits. No wrap beyond div_reg; the counter never reaches 2^CNT_W-1 unless div_reg=2^CNT_W-1+1 is impossible, so the maximum divisor is 2^CNT_W-1.
- Outputs are glitch-free registers; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset then load div_in=3, periodic, en=1, SUB_DIV=4 -> clk_en high on edges 3,6,9,12 after RUN entry; sub_en only on the 12th edge; busy=1 throughout.
2. div_in=0 loaded, periodic, en=1 -> div_reg=1; clk_en continuously high from the first RUN edge.
3. One-shot, div=5, start pulse with en=1 -> busy high 5 cycles; single clk_en on edge 5; busy=0 same cycle. A second start during RUN produces no extra pulse.
4. Periodic, div=4, drop en at count==3 -> no clk_en; IDLE next edge. Re-raise en -> first clk_en 4 edges later; sub_cnt value preserved.
5. RUN with div=10, div_load of 2 at count=7 -> next clk_en 2 edges after the load; period 2 thereafter; sub_cnt restarted at 0.
6. Assert reset low mid-RUN, asynchronously between edges -> clk_en, sub_en, busy drop to 0 immediately; div_reg returns to DIV_DEFAULT; after release, state is IDLE.
